// File: rtl/ram_bist.sv
// ram_bist -- march-style RAM built-in self test controller.
//
// Writes exp(a) = seed ^ a to every word, reads every word back and compares
// against the same pattern one cycle after each read. Reports the number of
// mismatches (saturating) and the address of the first mismatch of the run.
//
// Optional feature: define RAM_BIST_INV_PASS_EN to add a second write/read
// pass using the inverted pattern ~exp(a). Errors accumulate over both passes.
//
// Ports:
//   aclk, aresetn    clock (rising edge) and asynchronous active-low reset
//   start, seed      single-cycle run request and base pattern (latched on accept)
//   wren/wraddr/wrdata   RAM write port
//   rden/rdaddr/rddata   RAM read port, rddata valid one cycle after rden
//   busy, done, pass     run status; done holds until the next accepted start
//   err_count            mismatch count, saturating at 16'hFFFF
//   first_err_addr       address of the first mismatch of the run
module ram_bist #(
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 2 ** ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  wren,
    output logic [ADDR_WIDTH-1:0] wraddr,
    output logic [DATA_WIDTH-1:0] wrdata,
    output logic                  rden,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0] rddata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr, addr_next;
    logic [DATA_WIDTH-1:0] seed_q, seed_next;
    logic                  accept;
    logic [DATA_WIDTH-1:0] wr_pattern;
    logic [DATA_WIDTH-1:0] cmp_pattern;
    logic                  mismatch;

    // Compare stage: tracks which address the returning rddata belongs to.
    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;

`ifdef RAM_BIST_INV_PASS_EN
    logic inv_q, inv_next, inv_p1;
`endif

    function automatic logic [DATA_WIDTH-1:0] exp_word(
        input logic [DATA_WIDTH-1:0] base,
        input logic [ADDR_WIDTH-1:0] a
    );
        return base ^ DATA_WIDTH'(a);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_next = state;
        addr_next  = addr;
        seed_next  = seed_q;
        accept     = 1'b0;
`ifdef RAM_BIST_INV_PASS_EN
        inv_next   = inv_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    seed_next  = seed;
                    addr_next  = '0;
                    state_next = WRITE;
`ifdef RAM_BIST_INV_PASS_EN
                    inv_next   = 1'b0;
`endif
                end
            end
            WRITE: begin
                if (addr == LAST_ADDR) begin
                    addr_next  = '0;
                    state_next = READ;
                end else begin
                    addr_next  = addr + ADDR_WIDTH'(1);
                end
            end
            READ: begin
                if (addr == LAST_ADDR) begin
                    addr_next  = '0;
                    state_next = DRAIN;
                end else begin
                    addr_next  = addr + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
`ifdef RAM_BIST_INV_PASS_EN
                if (!inv_q) begin
                    inv_next   = 1'b1;
                    state_next = WRITE;
                end else begin
                    state_next = DONE;
                end
`else
                state_next = DONE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Write data is computed from the next-cycle seed/address so the
    // registered write port lines up with the WRITE state cycle.
`ifdef RAM_BIST_INV_PASS_EN
    assign wr_pattern  = inv_next ? ~exp_word(seed_next, addr_next) : exp_word(seed_next, addr_next);
    assign cmp_pattern = inv_p1 ? ~exp_word(seed_q, addr_p1) : exp_word(seed_q, addr_p1);
`else
    assign wr_pattern  = exp_word(seed_next, addr_next);
    assign cmp_pattern = exp_word(seed_q, addr_p1);
`endif

    assign mismatch = vld_p1 && (rddata != cmp_pattern);

    // Datapath, RAM port registers and error bookkeeping
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr           <= '0;
            seed_q         <= '0;
            wren           <= 1'b0;
            wraddr         <= '0;
            wrdata         <= '0;
            rden           <= 1'b0;
            rdaddr         <= '0;
            vld_p1         <= 1'b0;
            addr_p1        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
`ifdef RAM_BIST_INV_PASS_EN
            inv_q          <= 1'b0;
            inv_p1         <= 1'b0;
`endif
        end else begin
            addr   <= addr_next;
            seed_q <= seed_next;
            wren   <= (state_next == WRITE);
            rden   <= (state_next == READ);
            if (state_next == WRITE) begin
                wraddr <= addr_next;
                wrdata <= wr_pattern;
            end
            if (state_next == READ) begin
                rdaddr <= addr_next;
            end
            // Read issue -> compare stage
            vld_p1  <= rden;
            addr_p1 <= rdaddr;
`ifdef RAM_BIST_INV_PASS_EN
            inv_q  <= inv_next;
            inv_p1 <= inv_q;
`endif
            if (accept) begin
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (mismatch) begin
                err_count <= sat_inc(err_count);
                if (err_count == 16'd0) begin
                    first_err_addr <= addr_p1;
                end
            end
        end
    end

    assign busy = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist -- self-checking bench for ram_bist (256 x 32 RAM model with
// one-cycle read latency and per-address bit-0 read corruption).
module tb_ram_bist;

`ifdef RAM_BIST_INV_PASS_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif
    localparam int RUN_LEN = 2 * 256 * NP + NP;
    localparam int TIMEOUT = 3000;

    logic        clk = 1'b0;
    logic        aresetn = 1'b1;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic        wren, rden, busy, done, pass;
    logic [7:0]  wraddr, rdaddr, first_err_addr;
    logic [31:0] wrdata;
    logic [31:0] rddata = '0;
    logic [15:0] err_count;

    ram_bist #(.ADDR_WIDTH(8), .RAM_DEPTH(256), .DATA_WIDTH(32)) dut (
        .aclk(clk), .aresetn(aresetn), .start(start), .seed(seed),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .rden(rden), .rdaddr(rdaddr), .rddata(rddata),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    // RAM model with optional read corruption
    logic [31:0] mem [256];
    bit          c0_en = 1'b0, c1_en = 1'b0;
    logic [7:0]  c0 = '0, c1 = '0;

    always @(posedge clk) begin
        if (wren) mem[wraddr] <= wrdata;
        if (rden) rddata <= mem[rdaddr] ^ {31'd0, ((c0_en && rdaddr == c0) || (c1_en && rdaddr == c1))};
    end

    // Activity monitor: cumulative counts, port overlap, address sequence
    int         wr_total = 0, rd_total = 0, overlap = 0, seq_errs = 0;
    logic       prev_wren = 1'b0, prev_rden = 1'b0;
    logic [7:0] prev_wraddr = '0, prev_rdaddr = '0;

    always @(posedge clk) begin
        if (wren) wr_total <= wr_total + 1;
        if (rden) rd_total <= rd_total + 1;
        if (wren && rden) overlap <= overlap + 1;
        if (wren && (prev_wren ? (wraddr != 8'(prev_wraddr + 8'd1)) : (wraddr != 8'd0)))
            seq_errs <= seq_errs + 1;
        if (rden && (prev_rden ? (rdaddr != 8'(prev_rdaddr + 8'd1)) : (rdaddr != 8'd0)))
            seq_errs <= seq_errs + 1;
        prev_wren   <= wren;
        prev_rden   <= rden;
        prev_wraddr <= wraddr;
        prev_rdaddr <= rdaddr;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Called at a negedge. Pulses start, then counts cycles until done.
    // Snapshots status after the first edge and the write port after edge 100.
    task automatic run_test(input logic [31:0] s, input bit mid, output int cyc,
                            output logic b1, output logic d1, output logic p1,
                            output logic [15:0] e1, output logic [7:0] sa,
                            output logic [31:0] sd);
        cyc = 0; b1 = 0; d1 = 1; p1 = 1; e1 = 16'hDEAD; sa = '0; sd = '0;
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                b1 = busy; d1 = done; p1 = pass; e1 = err_count;
            end
            if (k == 100) begin
                sa = wraddr; sd = wrdata;
            end
            if (mid && k == 50) begin
                start = 1'b1;
                seed  = ~s;
            end
            if (mid && k == 51) start = 1'b0;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [31:0] seed;
        bit          c0_en;
        logic [7:0]  c0;
        bit          c1_en;
        logic [7:0]  c1;
        bit          mid;
        int          err1;
        logic [7:0]  first;
        bit          pass;
        logic [31:0] wd100;
    } vec_t;

    vec_t vecs[5];

    int          cyc, w0, r0;
    logic        b1, d1, p1;
    logic [15:0] e1;
    logic [7:0]  sa;
    logic [31:0] sd;

    initial begin
        vecs[0] = '{32'h0000BEEF, 0, 8'd0,  0, 8'd0,   0, 0, 8'd0,   1, 32'h0000BE8B};
        vecs[1] = '{32'h12345678, 1, 8'd34, 0, 8'd0,   0, 1, 8'd34,  0, 32'h1234561C};
        vecs[2] = '{32'hA5A5A5A5, 1, 8'd0,  1, 8'd255, 0, 2, 8'd0,   0, 32'hA5A5A5C1};
        vecs[3] = '{32'h0000BEEF, 0, 8'd0,  0, 8'd0,   1, 0, 8'd0,   1, 32'h0000BE8B};
        vecs[4] = '{32'hFFFFFFFF, 0, 8'd0,  1, 8'd255, 0, 1, 8'd255, 0, 32'hFFFFFF9B};

        // Reset state
        #1 aresetn = 1'b0;
        #2;
        check("rst_ctrl", {wren, rden, busy, done, pass}, 5'b0);
        check("rst_err_count", err_count, 16'd0);
        check("rst_first_err", first_err_addr, 8'd0);
        check("rst_addrs", {wraddr, rdaddr}, 16'd0);
        check("rst_wrdata", wrdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        // Table-driven runs
        for (int i = 0; i < 5; i++) begin
            c0_en = vecs[i].c0_en; c0 = vecs[i].c0;
            c1_en = vecs[i].c1_en; c1 = vecs[i].c1;
            w0 = wr_total; r0 = rd_total;
            run_test(vecs[i].seed, vecs[i].mid, cyc, b1, d1, p1, e1, sa, sd);
            check($sformatf("v%0d_cycles", i), cyc, RUN_LEN);
            check($sformatf("v%0d_pass", i), pass, vecs[i].pass);
            check($sformatf("v%0d_err_count", i), err_count, vecs[i].err1 * NP);
            check($sformatf("v%0d_first_err", i), first_err_addr, vecs[i].first);
            check($sformatf("v%0d_writes", i), wr_total - w0, 256 * NP);
            check($sformatf("v%0d_reads", i), rd_total - r0, 256 * NP);
            check($sformatf("v%0d_wraddr100", i), sa, 8'd100);
            check($sformatf("v%0d_wrdata100", i), sd, vecs[i].wd100);
            check($sformatf("v%0d_busy1", i), b1, 1'b1);
        end

        // Back-to-back start from DONE after a failing run
        c0_en = 0; c1_en = 0;
        run_test(32'h600DF00D, 0, cyc, b1, d1, p1, e1, sa, sd);
        check("b2b_done_cleared", d1, 1'b0);
        check("b2b_pass_cleared", p1, 1'b0);
        check("b2b_err_cleared", e1, 16'd0);
        check("b2b_cycles", cyc, RUN_LEN);
        check("b2b_pass", pass, 1'b1);

        // Reset during READ, after one error has been counted
        c0_en = 1; c0 = 8'd34;
        seed  = 32'h0BADCAFE;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        check("mid_read_rden", rden, 1'b1);
        check("mid_read_err", err_count, 16'd1);
        #2 aresetn = 1'b0;
        #1;
        check("abort_ctrl", {wren, rden, busy, done, pass}, 5'b0);
        check("abort_err", {err_count, first_err_addr}, 24'd0);
        check("abort_ports", {wraddr, rdaddr, wrdata}, 48'd0);
        @(negedge clk);
        aresetn = 1'b1;
        c0_en = 0;
        w0 = wr_total;
        repeat (5) @(negedge clk);
        check("post_abort_idle", {busy, done, pass}, 3'b0);
        check("post_abort_no_writes", wr_total - w0, 0);
        run_test(32'h0000B00B, 0, cyc, b1, d1, p1, e1, sa, sd);
        check("post_abort_cycles", cyc, RUN_LEN);
        check("post_abort_pass", pass, 1'b1);
        check("post_abort_wrdata100", sd, 32'h0000B06F);

        check("port_overlap", overlap, 0);
        check("addr_sequence", seq_errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
